// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle input path: update FSM encoding,
// default position geometry and the recentre value helper.
package pong_pkg;

  localparam int POS_W_DEF                = 8;
  localparam int MAX_POS_DEF              = 255;
  localparam int EDGES_PER_CLICK_LOG2_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND0 = 2'd1,
    SEND1 = 2'd2
  } upd_state_e;

  // Edge total that corresponds to the middle of the paddle range.
  function automatic int center_total(input int max_pos, input int edges_per_click_log2);
    return (max_pos / 2) << edges_per_click_log2;
  endfunction

endpackage

// File: rtl/quad_step.sv
// One paddle channel: synchronises the raw quadrature phases, decodes
// steps, keeps a saturating edge total and exposes the click position.
module quad_step
  import pong_pkg::*;
#(
  parameter int POS_W                = POS_W_DEF,
  parameter int MAX_POS              = MAX_POS_DEF,
  parameter int EDGES_PER_CLICK_LOG2 = EDGES_PER_CLICK_LOG2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             center,
  output logic [POS_W-1:0] pos
);

  localparam int TW = POS_W + EDGES_PER_CLICK_LOG2;
  localparam logic [TW-1:0] TMAX    = TW'(MAX_POS << EDGES_PER_CLICK_LOG2);
  localparam logic [TW-1:0] TCENTER = TW'(center_total(MAX_POS, EDGES_PER_CLICK_LOG2));

  logic [2:0]    a_sync_q, a_sync_d;
  logic [2:0]    b_sync_q, b_sync_d;
  logic [TW-1:0] total_q, total_d;
  logic          step_en;
  logic          step_dir;

  // Decode one quadrature edge from the settled sync stages and update the
  // total; recentre overrides any step, and the limits simply hold.
  always_comb begin
    a_sync_d = {a_sync_q[1:0], a};
    b_sync_d = {b_sync_q[1:0], b};
    step_en  = (a_sync_q[1] ^ a_sync_q[2]) ^ (b_sync_q[1] ^ b_sync_q[2]);
    step_dir = a_sync_q[1] ^ b_sync_q[2];
    total_d  = total_q;
    if (center) begin
      total_d = TCENTER;
    end else if (step_en && step_dir && (total_q < TMAX)) begin
      total_d = total_q + TW'(1);
    end else if (step_en && !step_dir && (total_q != '0)) begin
      total_d = total_q - TW'(1);
    end
  end

  // Synchroniser chains and edge total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      total_q  <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      total_q  <= total_d;
    end
  end

  assign pos = total_q[TW-1:EDGES_PER_CLICK_LOG2];

endmodule

// File: rtl/paddle_input_scheduler.sv
// Turns two paddle encoders into positions, snapshots them at each frame
// start and hands the snapshots to the game logic one per handshake.
module paddle_input_scheduler
  import pong_pkg::*;
#(
  parameter int POS_W                = POS_W_DEF,
  parameter int MAX_POS              = MAX_POS_DEF,
  parameter int EDGES_PER_CLICK_LOG2 = EDGES_PER_CLICK_LOG2_DEF,
  parameter int ONLY_CHANGED         = 0
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             A0,
  input  logic             B0,
  input  logic             A1,
  input  logic             B1,
  input  logic             CENTER,
  input  logic             FRAME_START,
  output logic             UPD_VALID,
  output logic             UPD_PLAYER,
  output logic [POS_W-1:0] UPD_POS,
  input  logic             UPD_READY,
  output logic             OVERRUN,
  input  logic             CLEAR_OVERRUN,
  output logic [POS_W-1:0] POS0,
  output logic [POS_W-1:0] POS1
);

  localparam logic OC = (ONLY_CHANGED != 0);

  upd_state_e       state_q, state_d;
  logic [POS_W-1:0] snap0_q, snap0_d;
  logic [POS_W-1:0] snap1_q, snap1_d;
  logic [POS_W-1:0] last0_q, last0_d;
  logic [POS_W-1:0] last1_q, last1_d;
  logic             last0_vld_q, last0_vld_d;
  logic             last1_vld_q, last1_vld_d;
  logic             overrun_q, overrun_d;
  logic             skip0_live;
  logic             skip1_live;
  logic             skip1_snap;

  quad_step #(
    .POS_W                (POS_W),
    .MAX_POS              (MAX_POS),
    .EDGES_PER_CLICK_LOG2 (EDGES_PER_CLICK_LOG2)
  ) u_quad0 (
    .clk    (CLOCK),
    .rst    (RESET),
    .a      (A0),
    .b      (B0),
    .center (CENTER),
    .pos    (POS0)
  );

  quad_step #(
    .POS_W                (POS_W),
    .MAX_POS              (MAX_POS),
    .EDGES_PER_CLICK_LOG2 (EDGES_PER_CLICK_LOG2)
  ) u_quad1 (
    .clk    (CLOCK),
    .rst    (RESET),
    .a      (A1),
    .b      (B1),
    .center (CENTER),
    .pos    (POS1)
  );

  // Update scheduler: snapshot on frame start, offer player 0 then player 1,
  // skipping unchanged players when enabled, and flag frames that overrun.
  always_comb begin
    state_d     = state_q;
    snap0_d     = snap0_q;
    snap1_d     = snap1_q;
    last0_d     = last0_q;
    last1_d     = last1_q;
    last0_vld_d = last0_vld_q;
    last1_vld_d = last1_vld_q;
    overrun_d   = overrun_q;

    skip0_live = OC && last0_vld_q && (POS0 == last0_q);
    skip1_live = OC && last1_vld_q && (POS1 == last1_q);
    skip1_snap = OC && last1_vld_q && (snap1_q == last1_q);

    if (CLEAR_OVERRUN) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (FRAME_START) begin
          snap0_d = POS0;
          snap1_d = POS1;
          if (!skip0_live) begin
            state_d = SEND0;
          end else if (!skip1_live) begin
            state_d = SEND1;
          end
        end
      end
      SEND0: begin
        if (FRAME_START) begin
          overrun_d = 1'b1;
        end
        if (UPD_READY) begin
          last0_d     = snap0_q;
          last0_vld_d = 1'b1;
          state_d     = skip1_snap ? IDLE : SEND1;
        end
      end
      SEND1: begin
        if (FRAME_START) begin
          overrun_d = 1'b1;
        end
        if (UPD_READY) begin
          last1_d     = snap1_q;
          last1_vld_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (CENTER) begin
      last0_vld_d = 1'b0;
      last1_vld_d = 1'b0;
    end
  end

  // Scheduler state, snapshots, last-delivered values and overrun flag.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      snap0_q     <= '0;
      snap1_q     <= '0;
      last0_q     <= '0;
      last1_q     <= '0;
      last0_vld_q <= 1'b0;
      last1_vld_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap0_q     <= snap0_d;
      snap1_q     <= snap1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      last0_vld_q <= last0_vld_d;
      last1_vld_q <= last1_vld_d;
      overrun_q   <= overrun_d;
    end
  end

  // Update port decoded straight from the state so reset drops it at once.
  always_comb begin
    UPD_VALID  = (state_q != IDLE);
    UPD_PLAYER = (state_q == SEND1);
    UPD_POS    = '0;
    if (state_q == SEND0) begin
      UPD_POS = snap0_q;
    end else if (state_q == SEND1) begin
      UPD_POS = snap1_q;
    end
  end

  assign OVERRUN = overrun_q;

endmodule
